mux_rr_feeder: RTL and testbench

- Upstream feeder and result collector for the 4:1 mux.
- Accepts four independent 4-bit request channels over valid/ready, buffers one word per channel, and arbitrates round-robin.
- Drives the mux data inputs ip1..ip4 and select, then registers the mux result into a valid/ready output stage tagged with the channel number.
- The mux itself stays external and purely combinational; its out returns on mux_out.

---
 rtl/mux_rr_feeder_pkg.sv | 25 ++
 rtl/mux_rr_feeder_if.sv | 27 ++
 rtl/mux_rr_feeder_rr_arb4.sv | 13 +
 rtl/mux_rr_feeder.sv | 138 +++++++++++++
 tb/tb_mux_rr_feeder.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_rr_feeder_pkg.sv
// Shared constants, FSM state type and round-robin helper for the mux feeder.
package mux_rr_pkg;

  localparam int DW  = 4;
  localparam int SW  = 2;
  localparam int NCH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_e;

  // First requesting channel after 'last', wrapping; returns 'last' when idle.
  // Scans from the farthest candidate down so the nearest one wins.
  function automatic logic [1:0] next_rr(input logic [1:0] last,
                                         input logic [3:0] req);
    logic [1:0] idx;
    next_rr = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) next_rr = idx;
    end
  endfunction

endpackage

// File: rtl/mux_rr_feeder_if.sv
// Request channels and result stream of the mux feeder.
// slave = the feeder, master = whoever drives requests and sinks results.
interface mux_rr_feeder_if #(
  parameter int DW = 4,
  parameter int SW = 2
);
  logic [3:0]    in_valid;
  logic [DW-1:0] in_data0;
  logic [DW-1:0] in_data1;
  logic [DW-1:0] in_data2;
  logic [DW-1:0] in_data3;
  logic [3:0]    in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_ch;
  logic          out_ready;

  modport slave (
    input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

  modport master (
    output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/mux_rr_feeder_rr_arb4.sv
// Combinational 4-way round-robin picker; priority starts just after 'last'.
module rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt,
  output logic       any
);
  import mux_rr_pkg::*;

  assign gnt = next_rr(last, req);
  assign any = |req;

endmodule

// File: rtl/mux_rr_feeder.sv
// Feeder/collector around an external combinational 4:1 mux.
// One holding slot per channel, round-robin select, registered result stage.
module mux_rr_feeder #(
  parameter int DW = 4,
  parameter int SW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mux_rr_feeder_if.slave       bus,
  output logic [DW-1:0]        ip1,
  output logic [DW-1:0]        ip2,
  output logic [DW-1:0]        ip3,
  output logic [DW-1:0]        ip4,
  output logic [SW-1:0]        sel,
  input  logic [DW-1:0]        mux_out
);
  import mux_rr_pkg::*;

  logic [NCH-1:0]          w_hold_v;
  logic [NCH-1:0][DW-1:0]  w_hold_d;
  logic [NCH-1:0][DW-1:0]  w_in_data;
  logic [NCH-1:0]          w_in_ready;
  logic [NCH-1:0]          w_accept;

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [SW-1:0]           r_sel;
  logic [SW-1:0]           r_last;
  logic                    r_out_valid;
  logic [DW-1:0]           r_out_data;
  logic [SW-1:0]           r_out_ch;

  logic [1:0]              w_gnt;
  logic                    w_any;
  logic                    w_out_free;
  logic                    w_load_sel;
  logic                    w_capture;

  assign w_in_data  = {bus.in_data3, bus.in_data2, bus.in_data1, bus.in_data0};
  // A slot only takes a word when empty; nothing is accepted while in reset.
  assign w_in_ready = ~w_hold_v & {NCH{~rst}};
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_out_free = ~r_out_valid | bus.out_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;

  // Mux inputs mirror the slots regardless of occupancy.
  assign ip1 = w_hold_d[0];
  assign ip2 = w_hold_d[1];
  assign ip3 = w_hold_d[2];
  assign ip4 = w_hold_d[3];
  assign sel = r_sel;

  // Per-channel holding slot. Load and release never coincide: a full slot
  // is not ready, and only a full slot can be the one being captured.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic          r_v;
    logic [DW-1:0] r_d;

    // Fill on handshake, drain when the captured result came from this slot.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v <= 1'b0;
        r_d <= '0;
      end else if (w_accept[i]) begin
        r_v <= 1'b1;
        r_d <= w_in_data[i];
      end else if (w_capture && (r_sel == SW'(i))) begin
        r_v <= 1'b0;
      end
    end

    assign w_hold_v[i] = r_v;
    assign w_hold_d[i] = r_d;
  end

  rr_arb4 u_arb (
    .req  (w_hold_v),
    .last (r_last),
    .gnt  (w_gnt),
    .any  (w_any)
  );

  // Next-state: pick a channel when one is pending and the output can take
  // it; capture the settled mux output on the following edge.
  always_comb begin
    w_state_nxt = r_state;
    w_load_sel  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any && w_out_free) begin
          w_load_sel  = 1'b1;
          w_state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (w_out_free) begin
          w_capture   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, select and round-robin pointer; sel only moves on IDLE->DRIVE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_last  <= SW'(NCH - 1);
    end else begin
      r_state <= w_state_nxt;
      if (w_load_sel) r_sel  <= w_gnt;
      if (w_capture)  r_last <= r_sel;
    end
  end

  // Result stage: capture wins over a simultaneous drain so no cycle is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_out_data  <= mux_out;
      r_out_ch    <= r_sel;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_feeder.sv
// Directed + random bench for mux_rr_feeder with a behavioural 4:1 mux.
// Per-channel data queues are filled on input handshakes and drained by the
// output monitor; directed tests also queue the expected channel order.
module tb_mux_rr_feeder;
  localparam int DW  = 4;
  localparam int SW  = 2;
  localparam int NCH = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] ip1, ip2, ip3, ip4;
  logic [SW-1:0] sel;
  logic [DW-1:0] mux_out;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] dq [NCH][$];
  logic [SW-1:0] ord_q [$];

  mux_rr_feeder_if #(.DW(DW), .SW(SW)) bus ();

  mux_rr_feeder #(.DW(DW), .SW(SW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .ip1     (ip1),
    .ip2     (ip2),
    .ip3     (ip3),
    .ip4     (ip4),
    .sel     (sel),
    .mux_out (mux_out)
  );

  // External mux model
  always_comb begin
    case (sel)
      2'd0:    mux_out = ip1;
      2'd1:    mux_out = ip2;
      2'd2:    mux_out = ip3;
      default: mux_out = ip4;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] in_word(input int i);
    case (i)
      0:       return bus.in_data0;
      1:       return bus.in_data1;
      2:       return bus.in_data2;
      default: return bus.in_data3;
    endcase
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NCH; i++) n += dq[i].size();
    return n;
  endfunction

  task automatic flush();
    for (int i = 0; i < NCH; i++) dq[i].delete();
    ord_q.delete();
  endtask

  // Monitor: compare handshaken results, then record newly accepted words.
  initial begin
    logic [SW-1:0] ch;
    logic [SW-1:0] ech;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        ch = bus.out_ch;
        if (ord_q.size() > 0) begin
          ech = ord_q.pop_front();
          chk("order_ch", 32'(ch), 32'(ech));
        end
        if (dq[ch].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: ch %0d data %0h, expected no output", ch, bus.out_data);
        end else begin
          chk("out_data_vs_accepted", 32'(bus.out_data), 32'(dq[ch].pop_front()));
        end
      end
      if (!rst) begin
        for (int i = 0; i < NCH; i++)
          if (bus.in_valid[i] && bus.in_ready[i]) dq[i].push_back(in_word(i));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1;
    flush();
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic saw;
    int   n;
    rst           = 1'b1;
    bus.in_valid  = '0;
    bus.in_data0  = '0;
    bus.in_data1  = '0;
    bus.in_data2  = '0;
    bus.in_data3  = '0;
    bus.out_ready = 1'b0;

    // Reset state
    tick();
    chk("rst_in_ready",  32'(bus.in_ready), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data",  32'(bus.out_data), 32'h0);
    chk("rst_out_ch",    32'(bus.out_ch), 32'h0);
    chk("rst_sel",       32'(sel), 32'h0);
    chk("rst_ip",        32'({ip4, ip3, ip2, ip1}), 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'hF);

    // Single word on ch2: sel one cycle after accept, result two cycles after
    bus.in_valid  = 4'b0100;
    bus.in_data2  = 4'hA;
    bus.out_ready = 1'b1;
    ord_q.push_back(2'd2);
    tick();
    bus.in_valid = '0;
    chk("single_in_ready2_low", 32'(bus.in_ready[2]), 32'h0);
    chk("single_no_early_valid", 32'(bus.out_valid), 32'h0);
    tick();
    chk("single_sel", 32'(sel), 32'h2);
    chk("single_not_yet", 32'(bus.out_valid), 32'h0);
    tick();
    chk("single_valid", 32'(bus.out_valid), 32'h1);
    chk("single_data",  32'(bus.out_data), 32'hA);
    chk("single_ch",    32'(bus.out_ch), 32'h2);
    chk("single_in_ready_back", 32'(bus.in_ready), 32'hF);
    tick();
    chk("single_valid_clear", 32'(bus.out_valid), 32'h0);

    // Full contention after reset: 0,1,2,3 at a 2-cycle cadence
    do_reset();
    bus.in_valid = 4'hF;
    bus.in_data0 = 4'h1;
    bus.in_data1 = 4'h2;
    bus.in_data2 = 4'h3;
    bus.in_data3 = 4'h4;
    for (int k = 0; k < 4; k++) ord_q.push_back(SW'(k));
    tick();
    bus.in_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("cont_gap", 32'(bus.out_valid), 32'h0);
      tick();
      chk("cont_valid", 32'(bus.out_valid), 32'h1);
      chk("cont_ch",    32'(bus.out_ch), 32'(k));
      chk("cont_data",  32'(bus.out_data), 32'(k + 1));
    end
    tick();

    // Fairness: ch1 granted, then ch3 ahead of ch0
    bus.in_valid = 4'b0010;
    bus.in_data1 = 4'h5;
    ord_q.push_back(2'd1);
    ord_q.push_back(2'd3);
    ord_q.push_back(2'd0);
    tick();
    bus.in_valid = 4'b1001;
    bus.in_data0 = 4'h6;
    bus.in_data3 = 4'h7;
    tick();
    bus.in_valid = '0;
    chk("rr_sel1", 32'(sel), 32'h1);
    tick();
    chk("rr_first_ch",   32'(bus.out_ch), 32'h1);
    chk("rr_first_data", 32'(bus.out_data), 32'h5);
    tick();
    tick();
    chk("rr_second_ch",   32'(bus.out_ch), 32'h3);
    chk("rr_second_data", 32'(bus.out_data), 32'h7);
    tick();
    tick();
    chk("rr_third_ch",   32'(bus.out_ch), 32'h0);
    chk("rr_third_data", 32'(bus.out_data), 32'h6);
    tick();

    // Backpressure: result held stable, second word waits for out_ready
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b0101;
    bus.in_data0  = 4'h9;
    bus.in_data2  = 4'h8;
    ord_q.push_back(2'd2);
    ord_q.push_back(2'd0);
    tick();
    bus.in_valid = '0;
    tick();
    chk("bp_sel", 32'(sel), 32'h2);
    tick();
    chk("bp_valid", 32'(bus.out_valid), 32'h1);
    chk("bp_data",  32'(bus.out_data), 32'h8);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_valid", 32'(bus.out_valid), 32'h1);
      chk("bp_hold_data",  32'(bus.out_data), 32'h8);
      chk("bp_hold_ch",    32'(bus.out_ch), 32'h2);
      chk("bp_hold_sel",   32'(sel), 32'h2);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_drained", 32'(bus.out_valid), 32'h0);
    chk("bp_next_sel", 32'(sel), 32'h0);
    tick();
    chk("bp_next_valid", 32'(bus.out_valid), 32'h1);
    chk("bp_next_data",  32'(bus.out_data), 32'h9);
    chk("bp_next_ch",    32'(bus.out_ch), 32'h0);
    tick();

    // Reset while in DRIVE with three words buffered
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1110;
    bus.in_data1  = 4'hB;
    bus.in_data2  = 4'hC;
    bus.in_data3  = 4'hD;
    tick();
    bus.in_valid = '0;
    tick();
    chk("mid_sel_before_rst", 32'(sel), 32'h1);
    rst = 1'b1;
    flush();
    #1;
    chk("mid_rst_in_ready",  32'(bus.in_ready), 32'h0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
    tick();
    chk("mid_rst_ip",  32'({ip4, ip3, ip2, ip1}), 32'h0);
    chk("mid_rst_sel", 32'(sel), 32'h0);
    rst = 1'b0;
    #1;
    chk("mid_release_in_ready", 32'(bus.in_ready), 32'hF);
    bus.out_ready = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      tick();
      if (bus.out_valid) saw = 1'b1;
    end
    chk("mid_no_stale", 32'(saw), 32'h0);

    // Random traffic: data/channel integrity checked by the monitor
    repeat (1000) begin
      bus.in_valid  = 4'($urandom);
      bus.in_data0  = 4'($urandom);
      bus.in_data1  = 4'($urandom);
      bus.in_data2  = 4'($urandom);
      bus.in_data3  = 4'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    n = 0;
    while ((pending() != 0 || bus.out_valid) && n < 64) begin
      tick();
      n++;
    end
    tick();
    chk("rand_drain_pending", 32'(pending()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
